// File: rtl/nes_bus_pkg.sv
// Shared NES CPU-bus definitions: DMA state encoding, register addresses
// and R/W polarity.
package nes_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ALIGN,
        READ,
        WRITE
    } dma_state_t;

    localparam logic [15:0] REG_OAMDMA  = 16'h4014;
    localparam logic [15:0] REG_OAMDATA = 16'h2004;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    localparam int XFER_LEN = 256;

endpackage

// File: rtl/dma_byte_counter.sv
// Byte counter for bus DMA engines: synchronous clear, increment, and a flag
// that is high while the count sits on the last byte of the transfer.
module dma_byte_counter #(
    parameter int               WIDTH    = 9,
    parameter logic [WIDTH-1:0] TERMINAL = WIDTH'(255)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clk_en,
    input  logic             clear,
    input  logic             incr,
    output logic [WIDTH-1:0] count,
    output logic             terminal
);

    // Count register: clear wins over increment, both only on enabled cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clk_en) begin
            if (clear) begin
                count <= '0;
            end else if (incr) begin
                count <= count + 1'b1;
            end
        end
    end

    assign terminal = (count == TERMINAL);

endmodule

// File: rtl/oam_dma_controller.sv
// OAM sprite DMA: a CPU write to $4014 halts the 6502 and copies one 256-byte
// page to $2004 as alternating read/write cycles.
// Optional feature macro: OAM_DMA_ALIGN_EN -- tracks get/put cycle parity and
// inserts one ALIGN cycle after an odd-parity halt so every read lands on a
// get cycle. Without it the parity flop and ALIGN path are absent.
module oam_dma_controller
    import nes_bus_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_clk_en,
    input  logic [15:0] i_cpu_address,
    input  logic [7:0]  i_cpu_data,
    input  logic        i_cpu_rw,
    input  logic [7:0]  i_bus_data,
    output logic        o_rdy,
    output logic        o_dma_active,
    output logic [15:0] o_address,
    output logic [7:0]  o_data,
    output logic        o_rw
);

    dma_state_t  state;
    dma_state_t  state_next;
    logic [7:0]  page;
    logic [7:0]  page_next;
    logic        rdy_next;
    logic        active_next;
    logic [15:0] address_next;
    logic [7:0]  data_next;
    logic        rw_next;

    logic        cnt_clear;
    logic        cnt_incr;
    logic [8:0]  count;
    logic        count_terminal;
    logic        xfer_done;
    logic [7:0]  next_lo;
    logic        trigger;
    logic        need_align;

    assign trigger   = (i_cpu_address == REG_OAMDMA) && (i_cpu_rw == RW_WRITE);
    assign xfer_done = count_terminal | count[8];
    assign next_lo   = count[7:0] + 8'd1;

`ifdef OAM_DMA_ALIGN_EN
    logic parity;

    // Get/put parity: free-running toggle on every enabled CPU cycle.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            parity <= 1'b0;
        end else if (i_clk_en) begin
            parity <= ~parity;
        end
    end

    assign need_align = parity;
`else
    assign need_align = 1'b0;
`endif

    dma_byte_counter #(
        .WIDTH   (9),
        .TERMINAL(9'(XFER_LEN - 1))
    ) u_byte_counter (
        .clk     (i_clk),
        .reset_n (i_reset_n),
        .clk_en  (i_clk_en),
        .clear   (cnt_clear),
        .incr    (cnt_incr),
        .count   (count),
        .terminal(count_terminal)
    );

    // Next-state and next-output logic; outputs describe the state being entered.
    always_comb begin
        state_next   = state;
        page_next    = page;
        rdy_next     = o_rdy;
        active_next  = o_dma_active;
        address_next = o_address;
        data_next    = o_data;
        rw_next      = o_rw;
        cnt_clear    = 1'b0;
        cnt_incr     = 1'b0;

        case (state)
            IDLE: begin
                if (trigger) begin
                    page_next   = i_cpu_data;
                    cnt_clear   = 1'b1;
                    rdy_next    = 1'b0;
                    active_next = 1'b0;
                    rw_next     = RW_READ;
                    state_next  = HALT;
                end
            end
            HALT: begin
                if (i_cpu_rw == RW_READ) begin
                    active_next = 1'b1;
                    rw_next     = RW_READ;
                    if (need_align) begin
                        state_next = ALIGN;
                    end else begin
                        address_next = {page, count[7:0]};
                        state_next   = READ;
                    end
                end
            end
            ALIGN: begin
                address_next = {page, count[7:0]};
                rw_next      = RW_READ;
                state_next   = READ;
            end
            READ: begin
                data_next    = i_bus_data;
                address_next = REG_OAMDATA;
                rw_next      = RW_WRITE;
                state_next   = WRITE;
            end
            WRITE: begin
                cnt_incr = 1'b1;
                rw_next  = RW_READ;
                if (xfer_done) begin
                    rdy_next    = 1'b1;
                    active_next = 1'b0;
                    state_next  = IDLE;
                end else begin
                    address_next = {page, next_lo};
                    state_next   = READ;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, page latch and registered bus outputs.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state        <= IDLE;
            page         <= 8'h00;
            o_rdy        <= 1'b1;
            o_dma_active <= 1'b0;
            o_address    <= 16'h0000;
            o_data       <= 8'h00;
            o_rw         <= RW_READ;
        end else if (i_clk_en) begin
            state        <= state_next;
            page         <= page_next;
            o_rdy        <= rdy_next;
            o_dma_active <= active_next;
            o_address    <= address_next;
            o_data       <= data_next;
            o_rw         <= rw_next;
        end
    end

endmodule
